// File: rtl/step_seq_pkg.sv
// step_seq_pkg: shared FSM state encoding and step counter width for the step sequencer
package step_seq_pkg;

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_FIRE, S_HOLD} step_state_t;

    localparam int STEP_CNT_W = 8;

endpackage

// File: rtl/step_sequencer_debounce_bit.sv
// debounce_bit: two-flop synchroniser followed by a stable-count debouncer for one raw input bit
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb
);

    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic meta;
    logic sync;
    logic [CW-1:0] cnt;

    // synchronise, then only follow the synchronised value once it has disagreed for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            deb  <= 1'b0;
            cnt  <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == deb) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                deb <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: debounced manual/auto step strobe generator with frozen switch vector for the FSM cores.
// Optional STEP_LIMIT_EN adds step_limit/limit_hit to stop stepping after a programmable number of steps.
module step_sequencer
    import step_seq_pkg::*;
#(
    parameter int SW_W            = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_step,
    input  logic [SW_W-1:0]       sw_raw,
    input  logic                  mode_auto,
`ifdef STEP_LIMIT_EN
    input  logic [STEP_CNT_W-1:0] step_limit,
    output logic                  limit_hit,
`endif
    output logic [SW_W-1:0]       sw_out,
    output logic                  step_pulse,
    output logic [STEP_CNT_W-1:0] step_count,
    output logic                  busy
);

    localparam int TW = AUTO_PERIOD > 1 ? $clog2(AUTO_PERIOD) : 1;
    localparam int WW = $clog2(DEBOUNCE_CYCLES + 3);
    localparam logic [TW-1:0] T_LAST = TW'(AUTO_PERIOD - 1);
    localparam logic [WW-1:0] W_DONE = WW'(DEBOUNCE_CYCLES + 2);

    step_state_t state, next;
    logic [SW_W:0]   raw_all, deb_all;
    logic [SW_W-1:0] sw_deb;
    logic            btn_deb;
    logic [1:0]      mode_s;
    logic            auto_m;
    logic [TW-1:0]   timer;
    logic            expire;
    logic [WW-1:0]   warm;
    logic            warm_done;
    logic            stop;

    assign raw_all = {btn_step, sw_raw};
    assign sw_deb  = deb_all[SW_W-1:0];
    assign btn_deb = deb_all[SW_W];
    assign auto_m  = mode_s[1];

    genvar i;
    generate
        for (i = 0; i <= SW_W; i++) begin : g_db
            debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk  (clk),
                .reset(reset),
                .raw  (raw_all[i]),
                .deb  (deb_all[i])
            );
        end
    endgenerate

`ifdef STEP_LIMIT_EN
    logic limit_q;
    assign limit_hit = limit_q | (step_limit != '0 && step_count == step_limit);
    assign stop      = limit_hit;

    // once the limit is reached it stays hit until reset, even if step_limit later changes
    always_ff @(posedge clk) begin
        limit_q <= reset ? 1'b0 : limit_hit;
    end
`else
    assign stop = 1'b0;
`endif

    assign expire     = auto_m && state == S_IDLE && timer == T_LAST;
    assign warm_done  = warm == W_DONE;
    assign busy       = state == S_LATCH || state == S_FIRE;
    assign step_pulse = state == S_FIRE;

    // mode select is a level, so a plain two-flop synchroniser is enough
    always_ff @(posedge clk) begin
        mode_s <= reset ? 2'b00 : {mode_s[0], mode_auto};
    end

    // after reset the debouncer reads 0 until it has observed the button, so S_HOLD waits long enough for a held button to show up
    always_ff @(posedge clk) begin
        warm <= reset ? '0 : warm_done ? warm : warm + 1'b1;
    end

    // auto timer keeps running through LATCH/FIRE so that consecutive strobes are exactly AUTO_PERIOD apart
    always_ff @(posedge clk) begin
        timer <= (reset || !auto_m || expire) ? '0 : state == S_HOLD ? timer : timer + 1'b1;
    end

    // next-state logic: triggers only in S_IDLE, manual steps wait in S_HOLD for the button to be released
    always_comb begin
        next = state;
        case (state)
            S_IDLE:  next = (!stop && (auto_m ? expire : btn_deb)) ? S_LATCH : S_IDLE;
            S_LATCH: next = S_FIRE;
            S_FIRE:  next = auto_m ? S_IDLE : S_HOLD;
            default: next = (!btn_deb && warm_done) ? S_IDLE : S_HOLD;
        endcase
    end

    // state, frozen switches and step count; sw_out loads on entry to S_LATCH so it leads the strobe by a cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_HOLD;
            sw_out     <= '0;
            step_count <= '0;
        end else begin
            state <= next;
            if (state == S_IDLE && next == S_LATCH) sw_out <= sw_deb;
            if (state == S_FIRE) step_count <= step_count + 1'b1;
        end
    end

endmodule
